// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit frame path.
// Optional build macro consumed by uart_tx_frame: UART_TX_TWO_STOP_EN.
package uart_tx_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      STOP2  = 3'd5
   } state_e;

   // Turns the XOR-reduction of the payload into the transmitted parity bit.
   function automatic logic par_sel(input logic red_xor, input logic typ);
      return (typ == PAR_EVEN) ? red_xor : ~red_xor;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// Current bit is slot 0; slot 1 is the bit shown after the next shift.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_bit,
   output logic                  o_bit_nxt,
   output logic                  o_done_c
);

   logic [DATA_WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0]      r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   assign o_bit     = r_shreg[0];
   assign o_bit_nxt = r_shreg[1];
   // Counter holds the index of the data bit currently on the line.
   assign o_done_c  = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start + LSB-first data + optional parity + stop, one bit per CLK.
// Define UART_TX_TWO_STOP_EN for two stop bits (back-to-back accept only in the second).
module uart_tx_frame
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

`ifdef UART_TX_TWO_STOP_EN
   localparam state_e LAST_STOP = STOP2;
`else
   localparam state_e LAST_STOP = STOP;
`endif

   state_e r_state;
   state_e w_state_nxt;
   logic   r_tx;
   logic   r_busy;
   logic   r_par_en;
   logic   r_par_bit;
   logic   w_tx_nxt;
   logic   w_busy_nxt;
   logic   w_load;
   logic   w_shift;
   logic   w_accept_c;
   logic   w_bit;
   logic   w_bit_nxt;
   logic   w_done_c;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .i_clk     (CLK),
      .i_rst_n   (RST),
      .i_load    (w_load),
      .i_shift   (w_shift),
      .i_data    (P_DATA),
      .o_bit     (w_bit),
      .o_bit_nxt (w_bit_nxt),
      .o_done_c  (w_done_c)
   );

   // State, line level and per-frame parity settings.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_tx      <= IDLE_LVL;
         r_busy    <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         if (w_load) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= par_sel(^P_DATA, PAR_TYP);
         end
      end
   end

   // Line level is computed for the state being entered so TX_OUT stays registered.
   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = IDLE_LVL;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_accept_c  = Data_Valid && ((r_state == IDLE) || (r_state == LAST_STOP));

      case (r_state)
         IDLE: begin
            w_state_nxt = IDLE;
         end
         START: begin
            w_state_nxt = DATA;
            w_tx_nxt    = w_bit;
         end
         DATA: begin
            if (!w_done_c) begin
               w_shift  = 1'b1;
               w_tx_nxt = w_bit_nxt;
            end else if (r_par_en) begin
               w_state_nxt = PARITY;
               w_tx_nxt    = r_par_bit;
            end else begin
               w_state_nxt = STOP;
               w_tx_nxt    = STOP_BIT;
            end
         end
         PARITY: begin
            w_state_nxt = STOP;
            w_tx_nxt    = STOP_BIT;
         end
         STOP: begin
`ifdef UART_TX_TWO_STOP_EN
            w_state_nxt = STOP2;
            w_tx_nxt    = STOP_BIT;
`else
            w_state_nxt = IDLE;
`endif
         end
         STOP2: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // A request in idle or the final stop starts the next frame with no idle bit.
      if (w_accept_c) begin
         w_state_nxt = START;
         w_load      = 1'b1;
         w_tx_nxt    = START_BIT;
      end

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: queue-based line model plus directed frame literals.
module tb_uart_tx_frame;

   localparam int unsigned DW = 8;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif
   localparam int L0 = 1 + DW + NSTOP;

   logic          CLK        = 1'b0;
   logic          RST        = 1'b1;
   logic [DW-1:0] P_DATA     = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN     = 1'b0;
   logic          PAR_TYP    = 1'b0;
   logic          TX_OUT;
   logic          Busy;

   int n_pass  = 0;
   int n_total = 0;
   bit q[$];

   uart_tx_frame #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: queue of line bits still to appear, head is the bit currently on the line.
   initial begin : model
      bit            acc;
      logic [DW-1:0] d;
      forever begin
         @(posedge CLK or negedge RST);
         if (!RST) begin
            q.delete();
         end else begin
            acc = (Data_Valid === 1'b1) && (q.size() <= 1);
            d   = P_DATA;
            if (q.size() != 0) void'(q.pop_front());
            if (acc) begin
               q.push_back(1'b0);
               for (int i = 0; i < DW; i++) q.push_back(d[i]);
               if (PAR_EN) q.push_back(PAR_TYP ? ~^d : ^d);
               for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
            end
         end
      end
   end

   initial begin : compare
      logic e_tx;
      logic e_busy;
      forever begin
         @(negedge CLK);
         e_tx   = (q.size() != 0) ? q[0] : 1'b1;
         e_busy = (q.size() != 0);
         chk("line_tx", 32'(TX_OUT), 32'(e_tx));
         chk("line_busy", 32'(Busy), 32'(e_busy));
      end
   end

   // Called right after a negedge; sample i is the line during frame cycle i.
   task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input int n,
                       output logic [31:0] cap, output int bc);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      cap = '0; bc = 0;
      for (int i = 0; i < n; i++) begin
         cap[i] = TX_OUT;
         if (Busy) bc++;
         @(negedge CLK);
      end
   endtask

   initial begin : stim
      logic [31:0] cap;
      int          bc;
      logic [31:0] msk;

      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_tx", 32'(TX_OUT), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("idle_tx", 32'(TX_OUT), 32'd1);

      // 8'hA5 without parity
      msk = (32'd1 << L0) - 32'd1;
      send(8'hA5, 1'b0, 1'b0, L0 + 2, cap, bc);
      chk("a5_bits", cap & msk, (NSTOP == 2) ? 32'h74A : 32'h34A);
      chk("a5_busy_len", 32'(bc), 32'(L0));

      // 8'h03 with even then odd parity
      send(8'h03, 1'b1, 1'b0, L0 + 3, cap, bc);
      chk("par_even_bit", 32'(cap[9]), 32'd0);
      chk("par_even_len", 32'(bc), 32'(L0 + 1));
      send(8'h03, 1'b1, 1'b1, L0 + 3, cap, bc);
      chk("par_odd_bit", 32'(cap[9]), 32'd1);
      chk("par_odd_len", 32'(bc), 32'(L0 + 1));

      // 8'hFF: stop bit(s) at the frame tail
      send(8'hFF, 1'b0, 1'b0, L0 + 2, cap, bc);
      chk("ff_bits", cap & msk, (NSTOP == 2) ? 32'h7FE : 32'h3FE);

      // Back-to-back frames with Data_Valid held
      P_DATA = 8'h55; PAR_EN = 1'b0; Data_Valid = 1'b1;
      @(negedge CLK);
      P_DATA = 8'hAA;
      cap = '0; bc = 0;
      for (int i = 0; i < 2 * L0 + 2; i++) begin
         cap[i] = TX_OUT;
         if (Busy) bc++;
         if (i == L0) Data_Valid = 1'b0;
         @(negedge CLK);
      end
      chk("b2b_byte1", 32'(cap[8:1]), 32'h55);
      chk("b2b_stop", 32'(cap[L0-1]), 32'd1);
      chk("b2b_start2", 32'(cap[L0]), 32'd0);
      chk("b2b_byte2", 32'(cap[L0+8:L0+1]), 32'hAA);
      chk("b2b_busy", 32'(bc), 32'(2 * L0));

      // Mid-frame request and input changes are ignored
      P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      cap = '0; bc = 0;
      for (int i = 0; i < L0 + 4; i++) begin
         cap[i] = TX_OUT;
         if (Busy) bc++;
         if (i == 3) begin
            Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0;
         end
         if (i == 4) Data_Valid = 1'b0;
         @(negedge CLK);
      end
      chk("mid_byte", 32'(cap[8:1]), 32'h3C);
      chk("mid_par", 32'(cap[9]), 32'd1);
      chk("mid_busy", 32'(bc), 32'(L0 + 1));

      // Reset in the middle of a frame
      P_DATA = 8'hA5; PAR_EN = 1'b0; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("midrst_tx", 32'(TX_OUT), 32'd1);
      chk("midrst_busy", 32'(Busy), 32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (5) @(negedge CLK);
      chk("postrst_tx", 32'(TX_OUT), 32'd1);
      chk("postrst_busy", 32'(Busy), 32'd0);

      // Random traffic against the model
      repeat (800) begin
         Data_Valid = ($urandom_range(0, 3) == 0);
         P_DATA     = DW'($urandom);
         PAR_EN     = 1'($urandom_range(0, 1));
         PAR_TYP    = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      Data_Valid = 1'b0;
      repeat (L0 + 4) @(negedge CLK);
      chk("end_idle_busy", 32'(Busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
